// File: rtl/lcd_char_fifo.sv
// lcd_char_fifo: first-word-fall-through character buffer between the byte source and the LCD controller.
// Define LCD_FIFO_FILTER_EN to keep only printable, newline and backspace bytes (CR is stored as LF).
module lcd_char_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic [7:0]        wr_data,
    input  logic              wr_en,
    input  logic              fifo_data_read,
    output logic [7:0]        data_from_fifo,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [ADDR_W:0]   fill_count,
    output logic              overflow
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              byte_ok;
    logic [7:0]        byte_stored;
    logic              pop_ok;
    logic              push_ok;
    logic              drop_full;

`ifdef LCD_FIFO_FILTER_EN
    // Bytes the display cannot render are dropped before they reach any FIFO state.
    always_comb begin
        byte_ok     = 1'b0;
        byte_stored = wr_data;
        if (wr_data == 8'h0D) begin
            byte_ok     = 1'b1;
            byte_stored = 8'h0A;
        end else if (wr_data == 8'h0A || wr_data == 8'h08) begin
            byte_ok = 1'b1;
        end else if (wr_data >= 8'h20 && wr_data <= 8'h7E) begin
            byte_ok = 1'b1;
        end
    end
`else
    assign byte_ok     = 1'b1;
    assign byte_stored = wr_data;
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign fill_count = count;

    // A pop frees a slot in the same cycle, so a full FIFO can still take a write alongside it.
    assign pop_ok    = fifo_data_read && !fifo_empty;
    assign push_ok   = wr_en && byte_ok && (!fifo_full || pop_ok);
    assign drop_full = wr_en && byte_ok && fifo_full && !pop_ok;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + (ADDR_W+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (ADDR_W+1)'(1);
            end
            if (drop_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset and clear; the pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= byte_stored;
        end
    end

    assign data_from_fifo = fifo_empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_lcd_char_fifo.sv
// tb_lcd_char_fifo: scoreboard bench for lcd_char_fifo; honours LCD_FIFO_FILTER_EN when defined.
module tb_lcd_char_fifo;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              clear = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              wr_en = 1'b0;
    logic              fifo_data_read = 1'b0;
    logic [7:0]        data_from_fifo;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ADDR_W:0]   fill_count;
    logic              overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q [$];
    logic       exp_ovf = 1'b0;
    logic       pop_seen;
    logic [7:0] pop_exp;
    logic [7:0] pop_act;

    lcd_char_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .clear          (clear),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .fifo_data_read (fifo_data_read),
        .data_from_fifo (data_from_fifo),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fill_count     (fill_count),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    // {accepted, stored byte} for one incoming byte
    function automatic logic [8:0] model_filter(input logic [7:0] b);
`ifdef LCD_FIFO_FILTER_EN
        if (b == 8'h0D) return {1'b1, 8'h0A};
        if (b == 8'h0A || b == 8'h08) return {1'b1, b};
        if (b >= 8'h20 && b <= 8'h7E) return {1'b1, b};
        return {1'b0, b};
`else
        return {1'b1, b};
`endif
    endfunction

    // Drive one cycle of stimulus, advance the scoreboard model, and return #1 after the edge.
    task automatic drive_cycle(input logic we, input logic [7:0] d, input logic rd, input logic clr);
        logic [8:0] f;
        logic       full_now;
        logic       pop_now;
        @(negedge clock);
        wr_en = we;
        wr_data = d;
        fifo_data_read = rd;
        clear = clr;
        #1;
        pop_seen = 1'b0;
        f = model_filter(d);
        full_now = (exp_q.size() == DEPTH);
        pop_now = rd && (exp_q.size() != 0);
        if (clr) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            if (pop_now) begin
                pop_exp = exp_q.pop_front();
                pop_act = data_from_fifo;
                pop_seen = 1'b1;
            end
            if (we && f[8] && (!full_now || pop_now)) exp_q.push_back(f[7:0]);
            if (we && f[8] && full_now && !pop_now) exp_ovf = 1'b1;
        end
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        fifo_data_read = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if (fifo_empty !== 1'b1) begin n_errors++; $display("[TB] FAIL reset_empty: got %b expected 1", fifo_empty); end
        n_checks++;
        if (fifo_full !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_full: got %b expected 0", fifo_full); end
        n_checks++;
        if (fill_count !== 5'd0) begin n_errors++; $display("[TB] FAIL reset_count: got %0d expected 0", fill_count); end
        n_checks++;
        if (overflow !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++;
        if (data_from_fifo !== 8'h00) begin n_errors++; $display("[TB] FAIL reset_data: got %h expected 00", data_from_fifo); end
    endtask

    task automatic test_single();
        drive_cycle(1'b1, 8'h41, 1'b0, 1'b0);
        n_checks++;
        if (data_from_fifo !== 8'h41) begin n_errors++; $display("[TB] FAIL single_head: got %h expected 41", data_from_fifo); end
        n_checks++;
        if (fill_count !== 5'd1 || fifo_empty !== 1'b0) begin
            n_errors++; $display("[TB] FAIL single_count: got %0d/empty %b expected 1/empty 0", fill_count, fifo_empty);
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (!pop_seen || pop_act !== 8'h41) begin n_errors++; $display("[TB] FAIL single_pop: got %h expected 41", pop_act); end
        n_checks++;
        if (fifo_empty !== 1'b1 || data_from_fifo !== 8'h00) begin
            n_errors++; $display("[TB] FAIL single_drain: got empty %b data %h expected empty 1 data 00", fifo_empty, data_from_fifo);
        end
    endtask

    task automatic test_overflow_wrap();
        for (int i = 0; i < 17; i++) begin
            drive_cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
            if (i == 15) begin
                n_checks++;
                if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
                    n_errors++; $display("[TB] FAIL wrap_full16: got full %b ovf %b expected full 1 ovf 0", fifo_full, overflow);
                end
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || fill_count !== 5'd16) begin
            n_errors++; $display("[TB] FAIL wrap_overflow: got ovf %b count %0d expected ovf 1 count 16", overflow, fill_count);
        end
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (!pop_seen || pop_act !== pop_exp || pop_act !== 8'h30 + 8'(i)) begin
                n_errors++; $display("[TB] FAIL wrap_pop%0d: got %h expected %h", i, pop_act, 8'h30 + 8'(i));
            end
        end
        n_checks++;
        if (fifo_empty !== 1'b1 || overflow !== 1'b1) begin
            n_errors++; $display("[TB] FAIL wrap_sticky: got empty %b ovf %b expected empty 1 ovf 1", fifo_empty, overflow);
        end
    endtask

    task automatic test_full_simul();
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'($urandom_range(32, 126)), 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h5A, 1'b1, 1'b0);
        n_checks++;
        if (fill_count !== 5'd16 || overflow !== 1'b0 || fifo_full !== 1'b1) begin
            n_errors++; $display("[TB] FAIL simul_full: got count %0d ovf %b full %b expected 16 0 1", fill_count, overflow, fifo_full);
        end
        n_checks++;
        if (!pop_seen || pop_act !== pop_exp) begin n_errors++; $display("[TB] FAIL simul_pop: got %h expected %h", pop_act, pop_exp); end
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++;
            if (!pop_seen || pop_act !== pop_exp) begin n_errors++; $display("[TB] FAIL simul_drain%0d: got %h expected %h", i, pop_act, pop_exp); end
        end
        n_checks++;
        if (pop_act !== 8'h5A || fifo_empty !== 1'b1) begin
            n_errors++; $display("[TB] FAIL simul_last: got %h empty %b expected 5a empty 1", pop_act, fifo_empty);
        end
    endtask

    task automatic test_empty_pop();
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (fill_count !== 5'd0 || fifo_empty !== 1'b1 || data_from_fifo !== 8'h00 || overflow !== 1'b0) begin
            n_errors++; $display("[TB] FAIL empty_pop: got count %0d empty %b data %h ovf %b expected 0 1 00 0",
                                 fill_count, fifo_empty, data_from_fifo, overflow);
        end
        drive_cycle(1'b1, 8'h42, 1'b1, 1'b0);
        n_checks++;
        if (fill_count !== 5'd1 || data_from_fifo !== 8'h42) begin
            n_errors++; $display("[TB] FAIL empty_simul: got count %0d head %h expected 1 42", fill_count, data_from_fifo);
        end
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_filter();
        drive_cycle(1'b1, 8'h07, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h0D, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h61, 1'b0, 1'b0);
`ifdef LCD_FIFO_FILTER_EN
        n_checks++;
        if (fill_count !== 5'd2) begin n_errors++; $display("[TB] FAIL filter_count: got %0d expected 2", fill_count); end
        n_checks++;
        if (data_from_fifo !== 8'h0A) begin n_errors++; $display("[TB] FAIL filter_cr: got %h expected 0a", data_from_fifo); end
`else
        n_checks++;
        if (fill_count !== 5'd3) begin n_errors++; $display("[TB] FAIL filter_count: got %0d expected 3", fill_count); end
        n_checks++;
        if (data_from_fifo !== 8'h07) begin n_errors++; $display("[TB] FAIL filter_raw: got %h expected 07", data_from_fifo); end
`endif
        drive_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++;
        if (!pop_seen || pop_act !== pop_exp) begin n_errors++; $display("[TB] FAIL filter_pop: got %h expected %h", pop_act, pop_exp); end
    endtask

    task automatic test_clear();
        while (exp_q.size() < DEPTH) drive_cycle(1'b1, 8'h55, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h56, 1'b0, 1'b0);
        n_checks++;
        if (overflow !== 1'b1) begin n_errors++; $display("[TB] FAIL clear_pre_ovf: got %b expected 1", overflow); end
        drive_cycle(1'b1, 8'h57, 1'b1, 1'b1);
        n_checks++;
        if (fill_count !== 5'd0 || overflow !== 1'b0 || fifo_empty !== 1'b1 || data_from_fifo !== 8'h00) begin
            n_errors++; $display("[TB] FAIL clear_flush: got count %0d ovf %b empty %b data %h expected 0 0 1 00",
                                 fill_count, overflow, fifo_empty, data_from_fifo);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'h48 + 8'(i), 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        exp_ovf = 1'b0;
        n_checks++;
        if (fill_count !== 5'd0 || fifo_empty !== 1'b1 || data_from_fifo !== 8'h00) begin
            n_errors++; $display("[TB] FAIL async_reset: got count %0d empty %b data %h expected 0 1 00",
                                 fill_count, fifo_empty, data_from_fifo);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic       we;
        logic       rd;
        logic       clr;
        logic [7:0] exp_head;
        for (int i = 0; i < 400; i++) begin
            we  = (i < 200) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            rd  = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 63) == 0);
            drive_cycle(we, 8'($urandom_range(0, 255)), rd, clr);
            exp_head = (exp_q.size() == 0) ? 8'h00 : exp_q[0];
            n_checks++;
            if (fill_count !== 5'(exp_q.size()) || overflow !== exp_ovf || data_from_fifo !== exp_head ||
                fifo_empty !== (exp_q.size() == 0) || fifo_full !== (exp_q.size() == DEPTH)) begin
                n_errors++; $display("[TB] FAIL b2b_state%0d: got count %0d ovf %b head %h expected %0d %b %h",
                                     i, fill_count, overflow, data_from_fifo, exp_q.size(), exp_ovf, exp_head);
            end
            if (pop_seen) begin
                n_checks++;
                if (pop_act !== pop_exp) begin n_errors++; $display("[TB] FAIL b2b_pop%0d: got %h expected %h", i, pop_act, pop_exp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow_wrap();
        test_full_simul();
        test_empty_pop();
        test_filter();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lcd_char_fifo.md
# lcd_char_fifo

Character buffer between the byte source (keyboard/UART receive path) and the LCD controller. Stores 8-bit character codes in a first-word-fall-through FIFO. Presents the head entry on `data_from_fifo` together with `fifo_empty` and `fifo_full`. Pops one entry per `fifo_data_read` pulse issued by the LCD controller after each character or instruction cycle completes.

## Interface
- `DEPTH`, 16, number of entries; must be a power of two, minimum 4
- `ADDR_W`, 4, pointer width; must equal log2(`DEPTH`)
- `clock` input 1: single clock; all state updates on its rising edge
- `reset` input 1: asynchronous, active-low reset (asserted when 0); one clock, reset is asynchronous and active-low
- `clear` input 1: synchronous flush; active-high, one cycle
- `wr_data` input 8: character code from the upstream source
- `wr_en` input 1: write request; one byte per cycle when high
- `fifo_data_read` input 1: pop request from the LCD controller; one entry per cycle when high
- `data_from_fifo` output 8: head entry; 8'h00 while empty
- `fifo_empty` output 1: no entries stored
- `fifo_full` output 1: `DEPTH` entries stored
- `fill_count` output `ADDR_W`+1: number of stored entries, 0..`DEPTH`
- `overflow` output 1: sticky flag; a write was dropped because the FIFO was full

## Operation
- Storage: `DEPTH` x 8 register array. Write pointer and read pointer are `ADDR_W` bits wide and wrap modulo `DEPTH`. Occupancy counter is `ADDR_W`+1 bits.
- Write accepted = `wr_en` & (!`fifo_full` | pop accepted) & byte passes filter (see Configuration).
- An accepted write stores `wr_data` at the write pointer and increments the write pointer.
- Pop accepted = `fifo_data_read` & !`fifo_empty`. It increments the read pointer. A pop while empty is ignored and has no side effects.
- Count update: +1 on write only, -1 on pop only, unchanged on both or neither.
- Simultaneous write and pop when full: both accepted; count stays `DEPTH`; no overflow.
- Simultaneous write and pop when empty: pop ignored, write accepted; count becomes 1.
- Flags are decoded from the registered count: `fifo_empty` = (count==0), `fifo_full` = (count==`DEPTH`).
- `data_from_fifo` = array[read pointer] when !`fifo_empty`, otherwise 8'h00. It is a combinational read of registered state.
- `overflow` is set when `wr_en` & `fifo_full` & no pop accepted, for a byte that passes the filter. It holds until `reset` or `clear`.
- `clear`: pointers, count and `overflow` go to 0 on the next edge. Any write or pop in the same cycle is discarded. Array contents are not cleared.
- Reset (asynchronous, `reset`=0): pointers, count and `overflow` are 0 immediately. Outputs: `fifo_empty`=1, `fifo_full`=0, `fill_count`=0, `overflow`=0, `data_from_fifo`=8'h00. Array contents are not reset. Reset during operation discards all entries.

## Timing
- Write-to-visible latency is 1 cycle. After the accepting edge, `fifo_empty` falls and `data_from_fifo` shows the byte.
- Pop takes effect on the edge. The next entry, or 8'h00 with `fifo_empty`=1, is visible after that edge.
- The LCD controller holds `fifo_data_read` high for one cycle per consumed character. A level held for N cycles pops N entries.
- `fill_count`, `fifo_full` and `overflow` update on the same edge as the operation that changes them.
- No combinational path from `wr_en` or `wr_data` to any output. `data_from_fifo` depends on `fifo_data_read` only through registered state.

## Configuration
- `LCD_FIFO_FILTER_EN` defined:
  - Only these bytes are written: 8'h20–8'h7E (printable), 8'h0A (newline) and 8'h08 (backspace).
  - 8'h0D is stored as 8'h0A.
  - All other bytes are dropped silently. They do not change the count and never set `overflow`, even when the FIFO is full.
- `LCD_FIFO_FILTER_EN` undefined: every byte is stored unmodified; the filter term is constant true.

## Test plan
- Reset release: hold `reset`=0, then release → `fifo_empty`=1, `fifo_full`=0, `fill_count`=0, `overflow`=0, `data_from_fifo`=8'h00.
- Single write 8'h41, then idle → one cycle later `data_from_fifo`=8'h41, `fill_count`=1. Pulse `fifo_data_read` → `fifo_empty`=1, data 8'h00.
- Write 17 bytes 8'h30..8'h40 with `DEPTH`=16 → `fifo_full`=1 after the 16th. 17th dropped, `overflow`=1. Pops return 8'h30..8'h3F in order across pointer wrap.
- Full FIFO, same-cycle `wr_en` (8'h5A) and `fifo_data_read` → `fill_count` stays 16, `overflow` stays 0, 8'h5A is the last entry read out.
- Pop while empty, and simultaneous write 8'h42 + pop while empty → first has no effect; second leaves `fill_count`=1 with head 8'h42.
- With `LCD_FIFO_FILTER_EN`: write 8'h07, 8'h0D, 8'h61 → `fill_count`=2, entries read 8'h0A then 8'h61. Assert `clear` → `fill_count`=0, `overflow`=0 next cycle.
